// File: rtl/instr_encoder_loader_if.sv
// Field/handshake and instruction-memory write bundle for instr_encoder_loader.
// master = sequencer/bench side, slave = encoder side.
interface instr_encoder_loader_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  fmt;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [12:0] imm;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        full;
    logic        err;

    modport master (
        output in_valid, fmt, op, funct3, funct7, rd, rs1, rs2, imm,
        input  in_ready, wr_en, wr_addr, wr_data, full, err
    );

    modport slave (
        input  in_valid, fmt, op, funct3, funct7, rd, rs1, rs2, imm,
        output in_ready, wr_en, wr_addr, wr_data, full, err
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// RV32I R/I/S/B field encoder that fills instruction memory sequentially.
// Optional field legality checking (sticky err) is enabled by ENCODER_CHECK_EN.
module instr_encoder_loader #(
    parameter int unsigned DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input logic                    clk,
    input logic                    rst,
    input logic                    clear,
    instr_encoder_loader_if.slave  bus
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, ENC, WR, FULL} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   count, count_inc;
    logic            last;
    logic [31:0]     addr_q, data_q, word;
    logic [1:0]      fmt_q;
    logic [6:0]      op_q, f7_q;
    logic [2:0]      f3_q;
    logic [4:0]      rd_q, rs1_q, rs2_q;
    logic [12:0]     imm_q;

    assign count_inc   = count + 1'b1;
    assign last        = (count_inc == CW'(DEPTH));
    assign bus.full    = (state == FULL);
    assign bus.wr_addr = addr_q;
    assign bus.wr_data = data_q;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // wr_en is gated by clear/rst so an abort suppresses the strobe in the same cycle
    always_comb begin
        state_n      = state;
        bus.in_ready = 1'b0;
        bus.wr_en    = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (!clear && bus.in_valid) state_n = ENC;
            end
            ENC:  state_n = clear ? IDLE : WR;
            WR: begin
                bus.wr_en = !clear && !rst;
                state_n   = (clear || !last) ? IDLE : FULL;
            end
            FULL: if (clear) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        word = '0;
        case (fmt_q)
            2'b00:   word = {imm_q[11:0], rs1_q, f3_q, rd_q, op_q};
            2'b01:   word = {imm_q[11:5], rs2_q, rs1_q, f3_q, imm_q[4:0], op_q};
            2'b10:   word = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, f3_q,
                             imm_q[4:1], imm_q[11], op_q};
            default: word = {f7_q, rs2_q, rs1_q, f3_q, rd_q, op_q};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= BASE_ADDR;
            count  <= '0;
            data_q <= '0;
            fmt_q  <= '0;
            op_q   <= '0;
            f3_q   <= '0;
            f7_q   <= '0;
            rd_q   <= '0;
            rs1_q  <= '0;
            rs2_q  <= '0;
            imm_q  <= '0;
        end else if (clear) begin
            addr_q <= BASE_ADDR;
            count  <= '0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    fmt_q <= bus.fmt;
                    op_q  <= bus.op;
                    f3_q  <= bus.funct3;
                    f7_q  <= bus.funct7;
                    rd_q  <= bus.rd;
                    rs1_q <= bus.rs1;
                    rs2_q <= bus.rs2;
                    imm_q <= bus.imm;
                end
                ENC: data_q <= word;
                WR: begin
                    addr_q <= addr_q + 32'd4;
                    count  <= count_inc;
                end
                default: ;
            endcase
        end
    end

`ifdef ENCODER_CHECK_EN
    logic illegal, err_q;

    always_comb begin
        illegal = (op_q[1:0] != 2'b11);
        case (fmt_q)
            2'b10:        illegal = illegal | imm_q[0];
            2'b00, 2'b01: illegal = illegal | (imm_q[12] != imm_q[11]);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)                                      err_q <= 1'b0;
        else if (!clear && state == ENC && illegal)   err_q <= 1'b1;
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed + randomized bench for instr_encoder_loader (DEPTH=4) with an
// arithmetic encoding/legality model; err expectation follows ENCODER_CHECK_EN.
module tb_instr_encoder_loader;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_0000;
`ifdef ENCODER_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    typedef struct packed {
        logic [1:0]  fmt;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [12:0] imm;
    } req_t;

    logic clk, rst, clear;
    instr_encoder_loader_if bus ();

    instr_encoder_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .clear(clear), .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cnt      = 0;
    bit          err_m    = 1'b0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic req_t mk(input logic [1:0] fmt, input logic [6:0] op,
                                input logic [2:0] f3, input logic [6:0] f7,
                                input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [12:0] imm);
        req_t r;
        r.fmt = fmt; r.op = op; r.f3 = f3; r.f7 = f7;
        r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.imm = imm;
        return r;
    endfunction

    // Encoding built from the signed immediate value with shifts and masks
    function automatic logic [31:0] enc_model(input req_t r);
        int          v;
        logic [31:0] u, w;
        v = int'($signed(r.imm));
        u = 32'(v);
        w = 32'(r.op) | (32'(r.f3) << 12) | (32'(r.rs1) << 15);
        case (r.fmt)
            2'd0: w = w | (32'(r.rd) << 7) | ((u & 32'hFFF) << 20);
            2'd1: w = w | (32'(r.rs2) << 20) | ((u & 32'h1F) << 7)
                        | (((u >> 5) & 32'h7F) << 25);
            2'd2: w = w | (32'(r.rs2) << 20) | (((u >> 1) & 32'hF) << 8)
                        | (((u >> 11) & 32'h1) << 7) | (((u >> 5) & 32'h3F) << 25)
                        | (((u >> 12) & 32'h1) << 31);
            default: w = w | (32'(r.rd) << 7) | (32'(r.rs2) << 20) | (32'(r.f7) << 25);
        endcase
        return w;
    endfunction

    function automatic bit illegal_model(input req_t r);
        int v;
        bit bad;
        v   = int'($signed(r.imm));
        bad = (int'(r.op) % 4) != 3;
        if (r.fmt == 2'd2)      bad = bad || (v % 2 != 0);
        else if (r.fmt != 2'd3) bad = bad || (v < -2048) || (v > 2047);
        return bad;
    endfunction

    task automatic drive(input req_t r);
        bus.fmt = r.fmt; bus.op = r.op; bus.funct3 = r.f3; bus.funct7 = r.f7;
        bus.rd = r.rd; bus.rs1 = r.rs1; bus.rs2 = r.rs2; bus.imm = r.imm;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        chk({tag, "_wr_en"},    32'(bus.wr_en),    32'd0);
        chk({tag, "_wr_addr"},  bus.wr_addr,       BASE);
        chk({tag, "_wr_data"},  bus.wr_data,       32'd0);
        chk({tag, "_full"},     32'(bus.full),     32'd0);
        chk({tag, "_err"},      32'(bus.err),      32'd0);
    endtask

    // Issue one request from IDLE; optionally keep in_valid high with nxt presented
    task automatic do_req(input req_t r, input bit keep, input req_t nxt);
        logic [31:0] exp;
        exp = enc_model(r);
        drive(r);
        bus.in_valid = 1'b1;
        chk("idle_ready", 32'(bus.in_ready), 32'd1);
        tick;
        chk("enc_ready", 32'(bus.in_ready), 32'd0);
        chk("enc_wr_en", 32'(bus.wr_en),    32'd0);
        if (keep) drive(nxt);
        else      bus.in_valid = 1'b0;
        tick;
        if (CHECK_EN && illegal_model(r)) err_m = 1'b1;
        chk("wr_en",    32'(bus.wr_en),    32'd1);
        chk("wr_ready", 32'(bus.in_ready), 32'd0);
        chk("wr_addr",  bus.wr_addr,       BASE + 32'(4 * cnt));
        chk("wr_data",  bus.wr_data,       exp);
        chk("wr_err",   32'(bus.err),      32'(err_m));
        cnt++;
        tick;
        chk("post_wr_en", 32'(bus.wr_en),    32'd0);
        chk("hold_data",  bus.wr_data,       exp);
        chk("post_full",  32'(bus.full),     32'(cnt == DEPTH));
        chk("post_ready", 32'(bus.in_ready), 32'(cnt != DEPTH));
    endtask

    initial begin
        req_t ri, rs, rr, rb, r5, rb9, rnd, z;
        int unsigned gaps;

        z = '0;
        rst = 1'b1; clear = 1'b0; bus.in_valid = 1'b0;
        drive(z);
        tick; tick;
        chk_reset("reset");
        rst = 1'b0;

        // addi x1,x0,5
        do_req(mk(2'd0, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 13'd5), 1'b0, z);
        chk("addi_const", bus.wr_data, 32'h00500093);

        clear = 1'b1; tick; clear = 1'b0; cnt = 0;
        chk("clear_addr", bus.wr_addr, BASE);

        // back-to-back I,S,R,B with in_valid held; fills DEPTH=4
        ri = mk(2'd0, 7'b0000011, 3'b010, 7'd0, 5'd6, 5'd9, 5'd0, 13'h1FFC);
        rs = mk(2'd1, 7'b0100011, 3'b010, 7'd0, 5'd0, 5'd9, 5'd6, 13'd8);
        rr = mk(2'd3, 7'b0110011, 3'd0,   7'd0, 5'd4, 5'd5, 5'd6, 13'd0);
        rb = mk(2'd2, 7'b1100011, 3'd0,   7'd0, 5'd0, 5'd1, 5'd2, 13'd8);
        r5 = mk(2'd0, 7'b0010011, 3'd0,   7'd0, 5'd7, 5'd3, 5'd0, 13'd100);
        do_req(ri, 1'b1, rs); chk("lw_const",  bus.wr_data, 32'hFFC4A303);
        do_req(rs, 1'b1, rr); chk("sw_const",  bus.wr_data, 32'h0064A423);
        do_req(rr, 1'b1, rb); chk("add_const", bus.wr_data, 32'h00628233);
        do_req(rb, 1'b1, r5); chk("beq_const", bus.wr_data, 32'h00208463);

        // fifth request held off while FULL
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("full_hold",  32'(bus.full),     32'd1);
            chk("full_ready", 32'(bus.in_ready), 32'd0);
            chk("full_wr_en", 32'(bus.wr_en),    32'd0);
        end
        clear = 1'b1; tick; cnt = 0;
        chk("clr_full",  32'(bus.full),     32'd0);
        chk("clr_ready", 32'(bus.in_ready), 32'd1);
        chk("clr_addr",  bus.wr_addr,       BASE);
        // clear with in_valid in IDLE: request must not be taken
        tick; clear = 1'b0;
        chk("clr_wins_ready", 32'(bus.in_ready), 32'd1);
        do_req(r5, 1'b0, z);

        // clear during ENC
        drive(rr); bus.in_valid = 1'b1;
        tick;
        bus.in_valid = 1'b0; clear = 1'b1; #1;
        chk("clr_enc_wr_en", 32'(bus.wr_en), 32'd0);
        tick; clear = 1'b0; cnt = 0;
        chk("clr_enc_wr_en2", 32'(bus.wr_en),    32'd0);
        chk("clr_enc_addr",   bus.wr_addr,       BASE);
        chk("clr_enc_ready",  32'(bus.in_ready), 32'd1);
        tick;
        chk("clr_enc_nowr", 32'(bus.wr_en), 32'd0);

        // rst during WR
        drive(rs); bus.in_valid = 1'b1;
        tick;
        bus.in_valid = 1'b0;
        tick;
        rst = 1'b1; #1;
        chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
        tick;
        chk_reset("rst_wr");
        rst = 1'b0; cnt = 0; err_m = 1'b0;

        // B with odd immediate: bit 0 dropped, err only with checking enabled
        rb9 = mk(2'd2, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 13'd9);
        do_req(rb9, 1'b0, z);
        chk("b9_const", bus.wr_data, 32'h00208463);
        chk("b9_err",   32'(bus.err), 32'(CHECK_EN));
        clear = 1'b1; tick; clear = 1'b0; cnt = 0;
        chk("err_after_clear", 32'(bus.err), 32'(CHECK_EN));
        rst = 1'b1; tick;
        chk_reset("err_rst");
        rst = 1'b0; err_m = 1'b0;

        // randomized requests against the model
        for (int i = 0; i < 40; i++) begin
            if (cnt == DEPTH) begin
                clear = 1'b1; tick; clear = 1'b0; cnt = 0;
                chk("rnd_clr_full", 32'(bus.full), 32'd0);
            end
            gaps = $urandom_range(0, 2);
            for (int g = 0; g < int'(gaps); g++) begin
                tick;
                chk("rnd_gap_wr_en", 32'(bus.wr_en), 32'd0);
            end
            rnd.fmt = 2'($urandom);
            rnd.op  = {5'($urandom), ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b11};
            rnd.f3  = 3'($urandom);
            rnd.f7  = 7'($urandom);
            rnd.rd  = 5'($urandom);
            rnd.rs1 = 5'($urandom);
            rnd.rs2 = 5'($urandom);
            rnd.imm = 13'($urandom);
            do_req(rnd, 1'b0, z);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_encoder_loader.md
# instr_encoder_loader

Assembles RV32I instruction fields (R/I/S/B formats) into 32-bit machine words and writes them sequentially into instruction memory, producing exactly the encoding that `control_unit` and the immediate extender decode. It sits between the test or boot sequencer and the instruction-memory write port. Fields are accepted through a valid/ready handshake, and the block tracks the write address and fill level.

## Interface
- `DEPTH`, 64: number of 32-bit words writable before full.
- `BASE_ADDR`, 32'h0000_0000: byte address of the first write.
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `clear` in 1: synchronous restart.
  - Address returns to `BASE_ADDR`.
  - Count returns to 0.
  - State returns to IDLE.
- `in_valid` in 1: instruction fields valid.
- `in_ready` out 1: block can accept fields.
- `fmt` in 2: format select, using the ImmSrc numbering plus R.
  - 00 = I, 01 = S, 10 = B, 11 = R.
- `op` in 7: opcode.
- `funct3` in 3: funct3.
- `funct7` in 7: funct7, used for R format only.
- `rd`, `rs1`, `rs2` in 5 each: register indices.
- `imm` in 13: signed immediate.
  - I/S use `imm[11:0]`.
  - B uses `imm[12:0]`.
- `wr_en` out 1: instruction-memory write strobe.
- `wr_addr` out 32: byte address of the write.
- `wr_data` out 32: encoded instruction.
- `full` out 1: `DEPTH` words written.
- `err` out 1: sticky illegal-field flag (see Configuration).

## Operation
- States: IDLE, ENC, WR, FULL.
- IDLE:
  - `in_ready`=1.
  - When `in_valid`=1, latch all fields and go to ENC.
- ENC:
  - Form the word in the `wr_data` register, using these bit orders:
    - R: `funct7|rs2|rs1|funct3|rd|op`.
    - I: `imm[11:0]|rs1|funct3|rd|op`.
    - S: `imm[11:5]|rs2|rs1|funct3|imm[4:0]|op`.
    - B: `imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|op`.
  - Fields not used by the selected format are ignored.
  - Go to WR.
- WR:
  - `wr_en`=1 for exactly one cycle at the current `wr_addr`.
  - At the end of the cycle: `wr_addr += 4` and `count += 1`.
  - If the new count equals `DEPTH`, go to FULL; otherwise go to IDLE.
- FULL:
  - `in_ready`=0 and `full`=1.
  - The block stays here until `clear` or `rst`.
- `count` is $clog2(DEPTH+1) bits wide and never wraps.
- `wr_addr` is 32-bit modulo arithmetic.
- `in_ready` is combinational from state only; it never depends on `in_valid`.
- `clear` and `in_valid` in the same cycle: `clear` wins, and the fields are not accepted.
- `clear` during ENC or WR: the pending write is dropped, and `wr_en` is forced to 0 that cycle.
- `clear` does not reset `err`; only `rst` does.

## Timing
- Reset values:
  - State IDLE, `in_ready`=1.
  - `wr_en`=0, `wr_addr`=`BASE_ADDR`, `wr_data`=0.
  - `full`=0, `err`=0, count=0.
- `rst` has priority over `clear`.
- `rst` mid-operation aborts any pending write in the same cycle.
- Latency: fields accepted on edge N give `wr_en`=1 during cycle N+2.
- Throughput: one instruction per 3 cycles.
- `wr_addr` and `wr_data` are registered and stable for the whole `wr_en` cycle.
- `wr_data` holds the last word until the next ENC.
- `full` rises in the cycle after the final `wr_en`.

## Configuration
- `ENCODER_CHECK_EN` defined:
  - ENC checks the fields. Each of these is illegal:
    - B format with `imm[0]`=1.
    - I/S format with `imm[12]`≠`imm[11]` (value out of 12-bit range).
    - `op[1:0]`≠2'b11.
  - An illegal instruction sets `err` (sticky).
  - The word is still written with the illegal bits dropped, and the address still advances.
- `ENCODER_CHECK_EN` not defined:
  - No checking is done and `err` is tied 0.
  - `imm[0]` is silently dropped for B format.
  - `imm[12]` is ignored for I/S format.

## Test plan
- Reset, then I format `op`=0010011, `funct3`=0, `rd`=1, `rs1`=0, `imm`=5 (addi x1,x0,5).
  - Expect `wr_en` at cycle N+2 with `wr_addr`=0x0 and `wr_data`=0x00500093.
- Back-to-back I, S, R, B, with `in_valid` held high throughout:
  - I: `op`=0000011, `funct3`=010, `rd`=6, `rs1`=9, `imm`=-4 (lw x6,-4(x9)) → 0xFFC4A303 @ 0x0.
  - S: `op`=0100011, `funct3`=010, `rs1`=9, `rs2`=6, `imm`=8 (sw x6,8(x9)) → 0x0064A423 @ 0x4.
  - R: `op`=0110011, `funct3`=0, `funct7`=0, `rd`=4, `rs1`=5, `rs2`=6 (add x4,x5,x6) → 0x00628233 @ 0x8.
  - B: `op`=1100011, `funct3`=0, `rs1`=1, `rs2`=2, `imm`=8 (beq x1,x2,8) → 0x00208463 @ 0xC.
  - `in_ready` is low in ENC and WR.
- DEPTH=4, five requests:
  - Expect 4 writes, then `full`=1 and `in_ready`=0.
  - The fifth request is held unaccepted.
  - Pulse `clear`: `full`=0, the next write lands at 0x0, and the fifth request is accepted.
- Assert `clear` in the ENC cycle:
  - Expect no `wr_en`, `wr_addr`=0x0 and IDLE on the next cycle.
  - Repeat the same test with `rst` in the WR cycle: expect `wr_en` suppressed and all outputs at their reset values.
- `ENCODER_CHECK_EN` defined, B format with `imm`=9:
  - Expect `err`=1, written word = encoding of `imm`=8.
  - `err` stays 1 across `clear` and drops only on `rst`.
  - Same stimulus without the macro: `err`=0 and the same word is written.
